// File: rtl/regfile_sb_if.sv
// Bus between decode/write-back and the scoreboarded register file.
// master: pipeline side driving addresses, write-back and issue requests.
// slave:  the register file answering with read data, busy and issue status.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              busy_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ack;
    logic              stall;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data_a, busy_a, rd_data_b, busy_b, issue_ack, stall
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data_a, busy_a, rd_data_b, busy_b, issue_ack, stall
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, two combinational read
// ports with write-through bypass, one write-back port and one issue port.
// Optional hardwired zero register at address 0.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wr_sup;
    logic clr_v;
    logic hit_a;
    logic hit_b;
    logic hit_i;
    logic iss_zero;
    logic busy_i;
    logic issue_set;

    // A write to the zero register is dropped; while in reset the bypass is
    // disabled so every read reflects the cleared state.
    assign wr_sup = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign clr_v  = rst_n && bus.wr_en && !wr_sup;

    // Read port A: zero register, then bypass from write-back, then storage.
    always_comb begin
        hit_a = clr_v && (bus.wr_addr == bus.rd_addr_a);
        if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) begin
            bus.rd_data_a = '0;
            bus.busy_a    = 1'b0;
        end else begin
            bus.rd_data_a = hit_a ? bus.wr_data : mem[bus.rd_addr_a];
            bus.busy_a    = busy[bus.rd_addr_a] && !hit_a;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        hit_b = clr_v && (bus.wr_addr == bus.rd_addr_b);
        if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) begin
            bus.rd_data_b = '0;
            bus.busy_b    = 1'b0;
        end else begin
            bus.rd_data_b = hit_b ? bus.wr_data : mem[bus.rd_addr_b];
            bus.busy_b    = busy[bus.rd_addr_b] && !hit_b;
        end
    end

    // Issue: stall on a pending producer unless it retires this very cycle.
    always_comb begin
        hit_i         = clr_v && (bus.wr_addr == bus.issue_addr);
        iss_zero      = (ZERO_REG != 0) && (bus.issue_addr == '0);
        busy_i        = !iss_zero && busy[bus.issue_addr] && !hit_i;
        bus.stall     = bus.issue_en && busy_i;
        bus.issue_ack = bus.issue_en && !busy_i;
        issue_set     = bus.issue_ack && !iss_zero;
    end

    // Storage and scoreboard; the issue set comes last so a same-address
    // write-back plus reservation leaves the register busy for the new producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (clr_v) begin
                mem[bus.wr_addr]  <= bus.wr_data;
                busy[bus.wr_addr] <= 1'b0;
            end
            if (issue_set) begin
                busy[bus.issue_addr] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-based bench for regfile_sb: directed scenarios plus a
// model-driven random phase, three instances covering the parameter cases.
module tb_regfile_sb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            chk(it.tag, act, it.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.rd_addr_a = '0; bus0.rd_addr_b = '0; bus0.wr_en = 1'b0; bus0.wr_addr = '0;
        bus0.wr_data = '0; bus0.issue_en = 1'b0; bus0.issue_addr = '0;
        bus1.rd_addr_a = '0; bus1.rd_addr_b = '0; bus1.wr_en = 1'b0; bus1.wr_addr = '0;
        bus1.wr_data = '0; bus1.issue_en = 1'b0; bus1.issue_addr = '0;
        bus2.rd_addr_a = '0; bus2.rd_addr_b = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0;
        bus2.wr_data = '0; bus2.issue_en = 1'b0; bus2.issue_addr = '0;
    endtask

    function automatic logic [15:0] sw_val(input int i);
        return 16'hF000 | 16'(i << 8) | 16'(i * 17);
    endfunction

    // Reference behaviour of the ZERO_REG=1 / 32x32 instance for the random phase.
    task automatic model_push();
        logic [4:0] a, b, ia;
        logic       clr, hit_a, hit_b, hit_i, busy_i;
        a     = bus0.rd_addr_a;
        b     = bus0.rd_addr_b;
        ia    = bus0.issue_addr;
        clr   = bus0.wr_en && (bus0.wr_addr != 5'd0);
        hit_a = clr && (bus0.wr_addr == a);
        hit_b = clr && (bus0.wr_addr == b);
        hit_i = clr && (bus0.wr_addr == ia);
        busy_i = (ia != 5'd0) && m_busy[ia] && !hit_i;
        sb_push("rnd_rd_a", (a == 5'd0) ? 32'd0 : (hit_a ? bus0.wr_data : m_mem[a]));
        sb_push("rnd_busy_a", (a == 5'd0) ? 32'd0 : 32'(m_busy[a] && !hit_a));
        sb_push("rnd_rd_b", (b == 5'd0) ? 32'd0 : (hit_b ? bus0.wr_data : m_mem[b]));
        sb_push("rnd_busy_b", (b == 5'd0) ? 32'd0 : 32'(m_busy[b] && !hit_b));
        sb_push("rnd_stall", 32'(bus0.issue_en && busy_i));
        sb_push("rnd_ack", 32'(bus0.issue_en && !busy_i));
    endtask

    task automatic model_commit();
        if (bus0.wr_en && (bus0.wr_addr != 5'd0)) begin
            m_mem[bus0.wr_addr]  = bus0.wr_data;
            m_busy[bus0.wr_addr] = 1'b0;
        end
        if (bus0.issue_en && bus0.issue_addr != 5'd0 && !m_busy[bus0.issue_addr]) begin
            m_busy[bus0.issue_addr] = 1'b1;
        end
    endtask

    task automatic pop_dut0();
        sb_pop(bus0.rd_data_a);
        sb_pop(32'(bus0.busy_a));
        sb_pop(bus0.rd_data_b);
        sb_pop(32'(bus0.busy_b));
        sb_pop(32'(bus0.stall));
        sb_pop(32'(bus0.issue_ack));
    endtask

    initial begin
        idle();
        // reset state while rst_n is low from time 0
        #2;
        sb_push("rst0_rd_a", 32'd0); sb_push("rst0_busy_a", 32'd0); sb_push("rst0_stall", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a)); sb_pop(32'(bus0.stall));

        @(negedge clk);
        rst_n = 1'b1;
        // write r5 and reserve it in the same cycle
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
        bus0.issue_en = 1'b1; bus0.issue_addr = 5'd5; bus0.rd_addr_a = 5'd5;
        sb_push("r5_byp", 32'hDEADBEEF); sb_push("r5_busy_pre", 32'd0); sb_push("r5_ack", 32'd1);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a)); sb_pop(32'(bus0.issue_ack));
        tick();
        idle();
        bus0.rd_addr_a = 5'd5;
        sb_push("r5_stored", 32'hDEADBEEF); sb_push("r5_busy", 32'd1);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a));

        // asynchronous reset between edges
        #1;
        rst_n = 1'b0;
        sb_push("rst_rd_a", 32'd0); sb_push("rst_busy_a", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a));
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'h11111111;
        bus0.issue_en = 1'b1; bus0.issue_addr = 5'd6; bus0.rd_addr_b = 5'd6;
        sb_push("rst_nobyp", 32'd0); sb_push("rst_ack", 32'd1); sb_push("rst_stall", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.issue_ack)); sb_pop(32'(bus0.stall));
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        bus0.rd_addr_a = 5'd5; bus0.rd_addr_b = 5'd6;
        sb_push("post_rst_rd_a", 32'd0); sb_push("post_rst_busy_b", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_b));

        // write-through bypass on both ports
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd3; bus0.wr_data = 32'h12345678;
        bus0.rd_addr_a = 5'd3; bus0.rd_addr_b = 5'd3;
        sb_push("byp_a", 32'h12345678); sb_push("byp_b", 32'h12345678);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(bus0.rd_data_b);
        tick();
        bus0.wr_en = 1'b0; bus0.wr_data = 32'hCAFEF00D;
        sb_push("store_a", 32'h12345678); sb_push("store_b", 32'h12345678); sb_push("store_busy", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(bus0.rd_data_b); sb_pop(32'(bus0.busy_a));

        // zero register (dut0) against plain r0 (dut1)
        idle();
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd0; bus0.wr_data = 32'hFFFFFFFF;
        bus0.issue_en = 1'b1; bus0.issue_addr = 5'd0;
        bus1.wr_en = 1'b1; bus1.wr_addr = 5'd0; bus1.wr_data = 32'hFFFFFFFF;
        bus1.issue_en = 1'b1; bus1.issue_addr = 5'd0;
        sb_push("z_rd_a", 32'd0); sb_push("z_busy_a", 32'd0); sb_push("z_ack", 32'd1); sb_push("z_stall", 32'd0);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a)); sb_pop(32'(bus0.issue_ack)); sb_pop(32'(bus0.stall));
        tick();
        idle();
        sb_push("z_after_rd", 32'd0); sb_push("z_after_busy", 32'd0);
        sb_push("nz_r0_rd", 32'hFFFFFFFF); sb_push("nz_r0_busy", 32'd1);
        #1;
        sb_pop(bus0.rd_data_a); sb_pop(32'(bus0.busy_a));
        sb_pop(bus1.rd_data_a); sb_pop(32'(bus1.busy_a));

        // read-after-write through the scoreboard on r7
        bus0.issue_en = 1'b1; bus0.issue_addr = 5'd7;
        sb_push("raw_ack", 32'd1);
        #1;
        sb_pop(32'(bus0.issue_ack));
        tick();
        bus0.issue_en = 1'b0; bus0.rd_addr_b = 5'd7;
        sb_push("raw_busy1", 32'd1);
        #1;
        sb_pop(32'(bus0.busy_b));
        tick();
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd7; bus0.wr_data = 32'h55;
        sb_push("raw_wb_busy", 32'd0); sb_push("raw_wb_data", 32'h55);
        #1;
        sb_pop(32'(bus0.busy_b)); sb_pop(bus0.rd_data_b);
        tick();
        bus0.wr_en = 1'b0;
        sb_push("raw_done_busy", 32'd0); sb_push("raw_done_data", 32'h55);
        #1;
        sb_pop(32'(bus0.busy_b)); sb_pop(bus0.rd_data_b);

        // write-after-write stall on r9
        idle();
        bus0.issue_en = 1'b1; bus0.issue_addr = 5'd9;
        tick();
        bus0.rd_addr_a = 5'd9;
        sb_push("waw_stall", 32'd1); sb_push("waw_ack", 32'd0); sb_push("waw_busy", 32'd1);
        #1;
        sb_pop(32'(bus0.stall)); sb_pop(32'(bus0.issue_ack)); sb_pop(32'(bus0.busy_a));
        tick();
        sb_push("waw_hold_stall", 32'd1); sb_push("waw_hold_busy", 32'd1);
        #1;
        sb_pop(32'(bus0.stall)); sb_pop(32'(bus0.busy_a));
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd9; bus0.wr_data = 32'h99;
        sb_push("waw_clr_stall", 32'd0); sb_push("waw_clr_ack", 32'd1); sb_push("waw_clr_busy", 32'd0);
        #1;
        sb_pop(32'(bus0.stall)); sb_pop(32'(bus0.issue_ack)); sb_pop(32'(bus0.busy_a));
        tick();
        bus0.wr_en = 1'b0; bus0.issue_en = 1'b0;
        sb_push("waw_new_busy", 32'd1); sb_push("waw_new_data", 32'h99);
        #1;
        sb_pop(32'(bus0.busy_a)); sb_pop(bus0.rd_data_a);

        // 16-bit x 8 instance: fill every register, read back on both ports
        idle();
        for (int i = 0; i < 8; i++) begin
            bus2.wr_en = 1'b1; bus2.wr_addr = 3'(i); bus2.wr_data = sw_val(i);
            tick();
        end
        bus2.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus2.rd_addr_a = 3'(i); bus2.rd_addr_b = 3'(7 - i);
            sb_push("sw_a", (i == 0) ? 32'd0 : 32'(sw_val(i)));
            sb_push("sw_b", (i == 7) ? 32'd0 : 32'(sw_val(7 - i)));
            #1;
            sb_pop(32'(bus2.rd_data_a)); sb_pop(32'(bus2.rd_data_b));
        end

        // random phase against the reference model
        idle();
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            bus0.wr_en      = 1'($urandom_range(0, 1));
            bus0.wr_addr    = 5'($urandom_range(0, 7));
            bus0.wr_data    = $urandom;
            bus0.issue_en   = 1'($urandom_range(0, 1));
            bus0.issue_addr = 5'($urandom_range(0, 7));
            bus0.rd_addr_a  = 5'($urandom_range(0, 7));
            bus0.rd_addr_b  = 5'($urandom_range(0, 7));
            model_push();
            #1;
            pop_dut0();
            @(posedge clk);
            model_commit();
        end

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register scoreboard, for the next-generation datapath. It provides two combinational read ports and one clocked write port with write-through bypass. An optional hardwired zero register is supported. Each register has a busy bit: the issue stage sets it to reserve a destination, and the write-back stage clears it with the write. The block sits between decode (reads, issue) and write-back (writes), and reports read-after-write and write-after-write hazards to the pipeline control.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes, and is never busy
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rd_addr_a  input  ADDR_W  read port A address
- rd_data_a  output  DATA_W  read port A data
- busy_a  output  1  register at rd_addr_a has a pending write
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_b  output  DATA_W  read port B data
- busy_b  output  1  register at rd_addr_b has a pending write
- wr_en  input  1  write-back strobe
- wr_addr  input  ADDR_W  write-back destination
- wr_data  input  DATA_W  write-back data
- issue_en  input  1  request to reserve issue_addr as a destination
- issue_addr  input  ADDR_W  destination to reserve
- issue_ack  output  1  reservation accepted this cycle
- stall  output  1  issue_en held off by a write-after-write hazard

## Operation
- Storage: 2**ADDR_W x DATA_W data registers, plus a busy vector of 2**ADDR_W bits.
- Reads are combinational.
  - rd_data_x = wr_data when wr_en, wr_addr == rd_addr_x, and the address is not a suppressed zero register (write-through bypass). Otherwise rd_data_x = the stored value.
  - When ZERO_REG = 1 and rd_addr_x == 0, rd_data_x = 0 and busy_x = 0 unconditionally.
- Effective clear: clr_v = wr_en for a non-suppressed wr_addr.
- busy_x = busy[rd_addr_x] AND NOT (clr_v AND wr_addr == rd_addr_x). A register being written back this cycle reads as not busy, with the bypassed data.
- stall = issue_en AND busy_eff[issue_addr], where busy_eff is the bypassed busy defined above.
- issue_ack = issue_en AND NOT stall. When ZERO_REG = 1 and issue_addr == 0, issue_ack = 1 and no bit is set.
- Write: on the rising edge with clr_v, data[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue: on the rising edge with issue_ack for a non-zero (or non-suppressed) address, busy[issue_addr] <= 1.
- Simultaneous clear and issue on the same address: the write lands and busy ends at 1 (the new producer wins). This is legal because the clear removes the stall in the same cycle.
- Writes to a register whose busy bit is 0 are accepted (unscoreboarded write) and leave busy at 0.
- No ordering is enforced between write-back and reads; pipeline control must honour busy_a and busy_b.

## Timing
- Reset (rst_n low, asynchronous): all data registers become 0 and all busy bits become 0 immediately.
  - During reset, every output reflects the reset state: rd_data_a/b = 0 (bypass is disabled while rst_n is low), busy_a/b = 0, stall = 0.
  - issue_ack follows issue_en, but the reservation is discarded.
- Reset asserted mid-operation drops all pending reservations; nothing is retained.
- Reset release is synchronous in effect: the first capturing edge is the first rising clk edge with rst_n high.
- Read latency is 0 cycles. A written value is visible in the same cycle through the bypass and from storage on every following cycle.
- Busy latency: a reservation accepted at edge N shows as busy_x = 1 from just after edge N until the edge that commits the matching write.
- Address wrap-around does not occur: all addresses are in range by construction (depth = 2**ADDR_W).

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low between edges. rd_addr_a = 5 must give rd_data_a = 0 immediately, with busy_a = 0.
- Bypass: wr_en = 1, wr_addr = 3, wr_data = 0x12345678, rd_addr_a = rd_addr_b = 3 in the same cycle. Both read ports must show 0x12345678 before the edge, and the stored value after it.
- Zero register: with ZERO_REG = 1, write 0xFFFFFFFF to r0 and issue r0. rd_data_a = 0, busy_a = 0, issue_ack = 1, stall = 0. Rerun with ZERO_REG = 0: r0 must store 0xFFFFFFFF.
- Scoreboard RAW: issue r7 (ack = 1). Next cycle rd_addr_b = 7 must give busy_b = 1. Write r7 = 0x55 two cycles later: busy_b = 0 and rd_data_b = 0x55 in the write cycle.
- WAW stall: with r9 busy, issue_en for r9 must give stall = 1, issue_ack = 0, and busy[r9] unchanged. In the cycle wr_en/wr_addr = 9 is also asserted: stall = 0, issue_ack = 1, and busy_a for r9 = 1 after the edge.
- Parameter sweep: DATA_W = 16, ADDR_W = 3. Write distinct values to all 8 registers, read back through both ports, and check the top address (7) and the width of the data.
